wb_tracker: RTL and testbench
=============================

WB_TRACKER -- requirements
Module: wb_tracker

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, memory address width (kept for parity with sibling trackers).
REQ-002 Parameter DATA_WIDTH, default 32, memory data width.
REQ-003 Parameter TRACE_DEPTH, default 4, output buffer depth in trace elements; power of two, minimum 2.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 counter  input  32 (integer)  free-running cycle count used for all timestamps.
REQ-007 ex_data_ready  input  1  EX tracker output valid; level, may stay high across cycles.
REQ-008 ex_data_i  input  trace_output  element from EX tracker.
REQ-009 data_rvalid_i  input  1  memory response valid from core data interface.
REQ-010 wb_data_o  output  trace_output  head of output buffer.
REQ-011 wb_data_valid_o  output  1  buffer non-empty.
REQ-012 wb_data_ready_i  input  1  downstream consumer accepts head.
REQ-013 overflow_o  output  1  sticky: an element was dropped.

Function
REQ-014 A new element is accepted when ex_data_ready=1 and ex_data_i.instruction differs from the last accepted instruction register; otherwise input is ignored.
REQ-015 FSM states: IDLE, WAIT_RVALID; reset state IDLE.
REQ-016 IDLE, new element with pass_through=1: wb_data.time_start=wb_data.time_end=counter, push in same cycle, stay IDLE.
REQ-017 IDLE, new element with pass_through=0: capture element, wb_data.time_start=counter, wb_data.mem_access_res.time_start=counter; if data_rvalid_i=1 in same cycle complete immediately per REQ-018, else go WAIT_RVALID.
REQ-018 WAIT_RVALID, data_rvalid_i=1: wb_data.time_end=counter, mem_access_res.time_end=counter, pass_through=1, push, go IDLE.
REQ-019 WAIT_RVALID ignores ex_data_ready; the last-accepted register is not updated, so a held EX element cannot be re-accepted.
REQ-020 Buffer is FIFO, first-word fall-through: element pushed at edge N is on wb_data_o with wb_data_valid_o=1 after edge N when buffer was empty.
REQ-021 Pop when wb_data_valid_o=1 and wb_data_ready_i=1.
REQ-022 Push when full and no pop: element dropped, overflow_o set, held until reset.
REQ-023 Push when full with simultaneous pop: push succeeds, no overflow.
REQ-024 Push and pop when empty: element written; wb_data_valid_o high next cycle.
REQ-025 Read/write pointers wrap modulo TRACE_DEPTH; occupancy counter width clog2(TRACE_DEPTH)+1.
REQ-026 Timestamps copied unmodified; counter wrap is not handled.
REQ-027 Fields not named in REQ-016..018 pass through from ex_data_i unchanged.

Reset
REQ-028 rst low: FSM=IDLE, buffer empty, pointers 0, wb_data_valid_o=0, overflow_o=0, wb_data_o=all zero, last-accepted instruction=0, captured element cleared.
REQ-029 Reset mid-WAIT_RVALID discards captured element; a later rvalid is ignored.
REQ-030 Reset deassertion takes effect on the next rising edge; no acceptance on the releasing edge.

Structure
REQ-031 wb_data sub-struct (time_start, time_end, mem_access_res{time_start,time_end}) is added to trace_output in package ryuki_datatypes.
REQ-032 FSM-state enum is local to the module; TRACE_DEPTH default lives in ryuki_datatypes.
REQ-033 One sub-module, trace_fifo (parameterised by depth, element type trace_output), owns storage, pointers, full/empty.

Verification
REQ-034 Pass-through element instr=0x00A00093 at counter=10, ready_i=1 -> wb_data_valid_o=1 next cycle, wb time_start=time_end=10.
REQ-035 Load, pass_through=0, accepted counter=20, rvalid at counter=23 -> time_start=20, mem_access_res 20..23, time_end=23, pass_through=1.
REQ-036 ex_data_ready held high 5 cycles with same instruction -> exactly one element pushed.
REQ-037 ready_i=0, six pass-through elements, TRACE_DEPTH=4 -> four buffered in order, overflow_o=1; then ready_i=1 -> four pops, valid drops.
REQ-038 Buffer full, push and pop same cycle -> occupancy stays 4, overflow_o=0.
REQ-039 rst low in WAIT_RVALID, rvalid after release -> no element output, all outputs at reset values.

Source files
------------

// File: rtl/ryuki_datatypes.sv
// Shared trace datatypes for the ryuki pipeline trace trackers.
package ryuki_datatypes;

   localparam int unsigned XLEN                = 32;
   localparam int unsigned DEFAULT_TRACE_DEPTH = 4;

   typedef struct packed {
      logic [31:0] time_start;
      logic [31:0] time_end;
   } mem_access_res_t;

   typedef struct packed {
      logic [31:0]     time_start;
      logic [31:0]     time_end;
      mem_access_res_t mem_access_res;
   } wb_data_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instruction;
      logic            pass_through;
      wb_data_t        wb_data;
   } trace_output;

   // Closes an outstanding memory access: stamps both end times and marks the element complete.
   function automatic trace_output close_mem_access(input trace_output e, input logic [31:0] ts);
      trace_output r;
      r = e;
      r.wb_data.time_end                = ts;
      r.wb_data.mem_access_res.time_end = ts;
      r.pass_through                    = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word fall-through FIFO of trace elements with sticky drop flag.
module trace_fifo
   import ryuki_datatypes::*;
#(
   parameter int unsigned DEPTH = DEFAULT_TRACE_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_i,
   input  trace_output push_data_i,
   input  logic        pop_i,
   output trace_output data_o,
   output logic        valid_o,
   output logic        overflow_o
);

   localparam int unsigned AW         = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   trace_output   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          overflow_q;
   logic          full;
   logic          do_pop;
   logic          do_push;
   logic          drop;

   assign valid_o    = (count_q != '0);
   assign full       = (count_q == FULL_COUNT);
   assign do_pop     = pop_i && valid_o;
   // A pop in the same cycle frees the slot, so a full buffer still accepts.
   assign do_push    = push_i && (!full || do_pop);
   assign drop       = push_i && full && !do_pop;
   assign data_o     = valid_o ? mem_q[rd_ptr_q] : '0;
   assign overflow_o = overflow_q;

   // Storage write port.
   // NOTE: the storage array has no reset; stale entries are never visible because data_o is gated by valid_o.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointers, occupancy and sticky overflow; pointers wrap naturally at the power-of-two depth.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (do_pop && !do_push) begin
            count_q <= count_q - 1'b1;
         end
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_tracker.sv
// Writeback-stage trace tracker: timestamps EX elements, waits for memory responses, buffers results.
module wb_tracker
   import ryuki_datatypes::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned TRACE_DEPTH = DEFAULT_TRACE_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] counter,
   input  logic        ex_data_ready,
   input  trace_output ex_data_i,
   input  logic        data_rvalid_i,
   output trace_output wb_data_o,
   output logic        wb_data_valid_o,
   input  logic        wb_data_ready_i,
   output logic        overflow_o
);

   // Trace fields are XLEN wide and the buffer needs a power-of-two depth of at least two.
   if (ADDR_WIDTH > XLEN || DATA_WIDTH > XLEN || TRACE_DEPTH < 2 ||
       (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("wb_tracker: unsupported ADDR_WIDTH/DATA_WIDTH/TRACE_DEPTH");
   end

   typedef enum logic {IDLE, WAIT_RVALID} state_e;

   state_e          state_q;
   state_e          state_d;
   logic [XLEN-1:0] last_instr_q;
   logic [XLEN-1:0] last_instr_d;
   trace_output     capt_q;
   trace_output     capt_d;
   trace_output     elem;
   trace_output     push_data;
   logic            push;
   logic            accept;

   // A held EX output repeats its instruction, so only a changed instruction counts as new.
   assign accept = ex_data_ready && (ex_data_i.instruction != last_instr_q);

   // Next state, capture and same-cycle push decision.
   always_comb begin
      // NOTE: every variable gets a default first so no branch can leave one unassigned and infer a latch.
      state_d                 = state_q;
      last_instr_d            = last_instr_q;
      capt_d                  = capt_q;
      push                    = 1'b0;
      elem                    = ex_data_i;
      elem.wb_data.time_start = counter;
      push_data               = elem;
      case (state_q)
         IDLE: begin
            if (accept) begin
               last_instr_d = ex_data_i.instruction;
               if (ex_data_i.pass_through) begin
                  push                        = 1'b1;
                  push_data.wb_data.time_end = counter;
               end else begin
                  elem.wb_data.mem_access_res.time_start = counter;
                  if (data_rvalid_i) begin
                     push      = 1'b1;
                     push_data = close_mem_access(elem, counter);
                  end else begin
                     capt_d  = elem;
                     state_d = WAIT_RVALID;
                  end
               end
            end
         end
         WAIT_RVALID: begin
            if (data_rvalid_i) begin
               push      = 1'b1;
               push_data = close_mem_access(capt_q, counter);
               capt_d    = '0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state, last-accepted instruction and captured element.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         last_instr_q <= '0;
         capt_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_instr_q <= last_instr_d;
         capt_q       <= capt_d;
      end
   end

   trace_fifo #(
      .DEPTH (TRACE_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (wb_data_ready_i),
      .data_o      (wb_data_o),
      .valid_o     (wb_data_valid_o),
      .overflow_o  (overflow_o)
   );

endmodule

// File: tb/tb_wb_tracker.sv
// Self-checking bench for wb_tracker: directed scenarios plus randomized transactions
// checked against a transaction-level model (expected-element queue with depth limit).
module tb_wb_tracker;
   import ryuki_datatypes::*;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] counter;
   logic        ex_data_ready;
   trace_output ex_data_i;
   logic        data_rvalid_i;
   trace_output wb_data_o;
   logic        wb_data_valid_o;
   logic        wb_data_ready_i;
   logic        overflow_o;

   int          total = 0;
   int          bad   = 0;
   trace_output exp_q[$];
   bit          exp_ovf;
   logic [31:0] last_acc;

   typedef struct {
      bit          rdy;
      trace_output ex;
      bit          rv;
      int unsigned act;  // 0 none, 1 pass-through push, 2 load accept, 3 load accept+complete, 4 load complete
      trace_output ld;
   } cyc_t;

   wb_tracker #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .TRACE_DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .counter         (counter),
      .ex_data_ready   (ex_data_ready),
      .ex_data_i       (ex_data_i),
      .data_rvalid_i   (data_rvalid_i),
      .wb_data_o       (wb_data_o),
      .wb_data_valid_o (wb_data_valid_o),
      .wb_data_ready_i (wb_data_ready_i),
      .overflow_o      (overflow_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want test completion");
      $fatal(1, "watchdog expired");
   end

   function automatic trace_output make_elem(input logic [31:0] instr, input logic pt);
      trace_output e;
      e.pc                                = $urandom;
      e.instruction                       = instr;
      e.pass_through                      = pt;
      e.wb_data.time_start                = $urandom;
      e.wb_data.time_end                  = $urandom;
      e.wb_data.mem_access_res.time_start = $urandom;
      e.wb_data.mem_access_res.time_end   = $urandom;
      return e;
   endfunction

   // Pass-through element: both writeback stamps take the acceptance time.
   function automatic trace_output exp_pt(input trace_output e, input logic [31:0] c);
      trace_output r = e;
      r.wb_data.time_start = c;
      r.wb_data.time_end   = c;
      return r;
   endfunction

   // Load element accepted at c1, response at c2.
   function automatic trace_output exp_load(input trace_output e, input logic [31:0] c1, input logic [31:0] c2);
      trace_output r = e;
      r.wb_data.time_start                = c1;
      r.wb_data.mem_access_res.time_start = c1;
      r.wb_data.time_end                  = c2;
      r.wb_data.mem_access_res.time_end   = c2;
      r.pass_through                      = 1'b1;
      return r;
   endfunction

   function automatic logic [31:0] new_instr();
      logic [31:0] v;
      do v = $urandom; while (v == 32'd0 || v == last_acc);
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      counter = counter + 32'd1;
   endtask

   // Advance one edge; the model applies the pop (if the head was offered and taken) and the push.
   task automatic tick(input bit do_push, input trace_output pe);
      bit pop_now;
      bit room;
      pop_now = wb_data_ready_i && (exp_q.size() > 0);
      room    = (exp_q.size() < DEPTH) || pop_now;
      if (pop_now) void'(exp_q.pop_front());
      if (do_push) begin
         if (room) exp_q.push_back(pe);
         else      exp_ovf = 1'b1;
      end
      step();
   endtask

   task automatic do_reset();
      rst             = 1'b0;
      ex_data_ready   = 1'b0;
      data_rvalid_i   = 1'b0;
      wb_data_ready_i = 1'b0;
      ex_data_i       = '0;
      exp_q.delete();
      exp_ovf  = 1'b0;
      last_acc = '0;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; counter = '0; ex_data_ready = 1'b0; ex_data_i = '0;
      data_rvalid_i = 1'b0; wb_data_ready_i = 1'b0;
      #1;
      total++; if (wb_data_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", wb_data_valid_o); end
      total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
      total++; if (wb_data_o !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", wb_data_o); end
      ex_data_ready = 1'b1;
      ex_data_i     = make_elem(32'h1234_5678, 1'b1);
      step();
      step();
      total++; if (wb_data_valid_o !== 1'b0) begin bad++; $display("FAIL reset_held_valid: got %b want 0", wb_data_valid_o); end
      do_reset();
   endtask

   task automatic test_pass_through();
      trace_output e, x;
      wb_data_ready_i = 1'b1;
      counter         = 32'd10;
      e               = make_elem(32'h00A0_0093, 1'b1);
      ex_data_i       = e;
      ex_data_ready   = 1'b1;
      x               = exp_pt(e, 32'd10);
      tick(1'b1, x);
      last_acc      = e.instruction;
      ex_data_ready = 1'b0;
      total++; if (wb_data_valid_o !== 1'b1) begin bad++; $display("FAIL pt_valid: got %b want 1", wb_data_valid_o); end
      total++; if (wb_data_o.wb_data.time_start !== 32'd10 || wb_data_o.wb_data.time_end !== 32'd10) begin
         bad++; $display("FAIL pt_times: got %0d..%0d want 10..10", wb_data_o.wb_data.time_start, wb_data_o.wb_data.time_end);
      end
      total++; if (wb_data_o !== x) begin bad++; $display("FAIL pt_elem: got %h want %h", wb_data_o, x); end
      tick(1'b0, '0);
      total++; if (wb_data_valid_o !== 1'b0 || wb_data_o !== '0) begin
         bad++; $display("FAIL pt_popped: got valid=%b data=%h want valid=0 data=0", wb_data_valid_o, wb_data_o);
      end
   endtask

   task automatic test_load();
      trace_output e, x;
      wb_data_ready_i = 1'b0;
      counter         = 32'd20;
      e               = make_elem(32'h0000_A103, 1'b0);
      ex_data_i       = e;
      ex_data_ready   = 1'b1;
      data_rvalid_i   = 1'b0;
      tick(1'b0, '0);
      last_acc = e.instruction;
      tick(1'b0, '0);
      tick(1'b0, '0);
      total++; if (wb_data_valid_o !== 1'b0) begin bad++; $display("FAIL load_wait_valid: got %b want 0", wb_data_valid_o); end
      data_rvalid_i = 1'b1;
      x = exp_load(e, 32'd20, 32'd23);
      tick(1'b1, x);
      data_rvalid_i = 1'b0;
      total++; if (wb_data_valid_o !== 1'b1) begin bad++; $display("FAIL load_valid: got %b want 1", wb_data_valid_o); end
      total++; if (wb_data_o.wb_data.time_start !== 32'd20 || wb_data_o.wb_data.time_end !== 32'd23) begin
         bad++; $display("FAIL load_times: got %0d..%0d want 20..23", wb_data_o.wb_data.time_start, wb_data_o.wb_data.time_end);
      end
      total++; if (wb_data_o.wb_data.mem_access_res.time_start !== 32'd20 || wb_data_o.wb_data.mem_access_res.time_end !== 32'd23) begin
         bad++; $display("FAIL load_mem_times: got %0d..%0d want 20..23",
                         wb_data_o.wb_data.mem_access_res.time_start, wb_data_o.wb_data.mem_access_res.time_end);
      end
      total++; if (wb_data_o.pass_through !== 1'b1) begin bad++; $display("FAIL load_pt: got %b want 1", wb_data_o.pass_through); end
      total++; if (wb_data_o !== x) begin bad++; $display("FAIL load_elem: got %h want %h", wb_data_o, x); end
      wb_data_ready_i = 1'b1;
      tick(1'b0, '0);
      ex_data_ready = 1'b0;
      total++; if (wb_data_valid_o !== 1'b0) begin bad++; $display("FAIL load_no_reaccept: got %b want 0", wb_data_valid_o); end
   endtask

   task automatic test_held();
      trace_output e, x;
      wb_data_ready_i = 1'b0;
      e               = make_elem(new_instr(), 1'b1);
      ex_data_i       = e;
      ex_data_ready   = 1'b1;
      x               = exp_pt(e, counter);
      tick(1'b1, x);
      last_acc = e.instruction;
      repeat (4) tick(1'b0, '0);
      ex_data_ready = 1'b0;
      total++; if (wb_data_valid_o !== 1'b1 || wb_data_o !== x) begin
         bad++; $display("FAIL held_one: got valid=%b data=%h want valid=1 data=%h", wb_data_valid_o, wb_data_o, x);
      end
      wb_data_ready_i = 1'b1;
      tick(1'b0, '0);
      total++; if (wb_data_valid_o !== 1'b0) begin bad++; $display("FAIL held_only_one: got %b want 0", wb_data_valid_o); end
   endtask

   task automatic test_overflow();
      trace_output e;
      do_reset();
      ex_data_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         e         = make_elem(new_instr(), 1'b1);
         ex_data_i = e;
         tick(1'b1, exp_pt(e, counter));
         last_acc = e.instruction;
      end
      ex_data_ready = 1'b0;
      total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow_o); end
      wb_data_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++; if (wb_data_valid_o !== 1'b1 || wb_data_o !== exp_q[0]) begin
            bad++; $display("FAIL ovf_pop%0d: got valid=%b data=%h want valid=1 data=%h", i, wb_data_valid_o, wb_data_o, exp_q[0]);
         end
         tick(1'b0, '0);
      end
      total++; if (wb_data_valid_o !== 1'b0) begin bad++; $display("FAIL ovf_drained: got %b want 0", wb_data_valid_o); end
      total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow_o); end
   endtask

   task automatic test_full_push_pop();
      trace_output e;
      do_reset();
      ex_data_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wb_data_ready_i = (i == 4);
         e               = make_elem(new_instr(), 1'b1);
         ex_data_i       = e;
         tick(1'b1, exp_pt(e, counter));
         last_acc = e.instruction;
      end
      ex_data_ready   = 1'b0;
      wb_data_ready_i = 1'b0;
      total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL fpp_overflow: got %b want 0", overflow_o); end
      wb_data_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++; if (wb_data_valid_o !== 1'b1 || wb_data_o !== exp_q[0]) begin
            bad++; $display("FAIL fpp_pop%0d: got valid=%b data=%h want valid=1 data=%h", i, wb_data_valid_o, wb_data_o, exp_q[0]);
         end
         tick(1'b0, '0);
      end
      total++; if (wb_data_valid_o !== 1'b0) begin bad++; $display("FAIL fpp_drained: got %b want 0", wb_data_valid_o); end
   endtask

   task automatic test_reset_wait();
      trace_output e;
      do_reset();
      e             = make_elem(new_instr(), 1'b1);
      ex_data_i     = e;
      ex_data_ready = 1'b1;
      tick(1'b1, exp_pt(e, counter));
      last_acc  = e.instruction;
      e         = make_elem(new_instr(), 1'b0);
      ex_data_i = e;
      tick(1'b0, '0);
      last_acc      = e.instruction;
      ex_data_ready = 1'b0;
      tick(1'b0, '0);
      total++; if (wb_data_valid_o !== 1'b1) begin bad++; $display("FAIL rw_prefill: got %b want 1", wb_data_valid_o); end
      rst = 1'b0;
      exp_q.delete(); exp_ovf = 1'b0; last_acc = '0;
      #1;
      total++; if (wb_data_valid_o !== 1'b0 || wb_data_o !== '0) begin
         bad++; $display("FAIL rw_async: got valid=%b data=%h want valid=0 data=0", wb_data_valid_o, wb_data_o);
      end
      step();
      rst             = 1'b1;
      wb_data_ready_i = 1'b0;
      data_rvalid_i   = 1'b1;
      tick(1'b0, '0);
      data_rvalid_i = 1'b0;
      tick(1'b0, '0);
      total++; if (wb_data_valid_o !== 1'b0 || wb_data_o !== '0) begin
         bad++; $display("FAIL rw_late_rvalid: got valid=%b data=%h want valid=0 data=0", wb_data_valid_o, wb_data_o);
      end
      total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL rw_overflow: got %b want 0", overflow_o); end
   endtask

   task automatic test_random();
      cyc_t        plan[$];
      cyc_t        c;
      trace_output e;
      trace_output want;
      logic [31:0] c1;
      int unsigned d;
      int          idx;
      do_reset();
      for (int t = 0; t < 250; t++) begin
         if ($urandom_range(0, 1) == 0) begin
            e = make_elem(new_instr(), 1'b1);
            last_acc = e.instruction;
            plan.push_back('{1'b1, e, 1'($urandom_range(0, 1)), 1, '0});
            repeat ($urandom_range(0, 2)) plan.push_back('{1'b1, e, 1'($urandom_range(0, 1)), 0, '0});
         end else begin
            e = make_elem(new_instr(), 1'b0);
            last_acc = e.instruction;
            d = $urandom_range(0, 3);
            if (d == 0) plan.push_back('{1'b1, e, 1'b1, 3, e});
            else        plan.push_back('{1'b1, e, 1'b0, 2, e});
            for (int k = 1; k <= int'(d); k++) begin
               if ($urandom_range(0, 1) == 0) c = '{1'b1, e, 1'b0, 0, e};
               else c = '{1'($urandom_range(0, 1)), make_elem($urandom, 1'($urandom_range(0, 1))), 1'b0, 0, e};
               c.rv  = (k == int'(d));
               c.act = (k == int'(d)) ? 4 : 0;
               plan.push_back(c);
            end
            plan.push_back('{1'b1, e, 1'b0, 0, '0});
         end
         if ($urandom_range(0, 1) == 0)
            plan.push_back('{1'b1, make_elem(last_acc, 1'($urandom_range(0, 1))), 1'($urandom_range(0, 1)), 0, '0});
         else
            plan.push_back('{1'b0, make_elem($urandom, 1'b1), 1'($urandom_range(0, 1)), 0, '0});
      end
      idx = 0;
      c1  = '0;
      foreach (plan[i]) begin
         c               = plan[i];
         ex_data_ready   = c.rdy;
         ex_data_i       = c.ex;
         data_rvalid_i   = c.rv;
         wb_data_ready_i = ($urandom_range(0, 3) < (((idx / 64) % 2 == 1) ? 1 : 3));
         idx++;
         want = '0;
         if (exp_q.size() > 0) want = exp_q[0];
         total++; if (wb_data_valid_o !== (exp_q.size() > 0)) begin
            bad++; $display("FAIL rnd_valid@%0d: got %b want %b", i, wb_data_valid_o, exp_q.size() > 0);
         end
         total++; if (wb_data_o !== want) begin bad++; $display("FAIL rnd_data@%0d: got %h want %h", i, wb_data_o, want); end
         total++; if (overflow_o !== exp_ovf) begin bad++; $display("FAIL rnd_ovf@%0d: got %b want %b", i, overflow_o, exp_ovf); end
         case (c.act)
            1: tick(1'b1, exp_pt(c.ex, counter));
            2: begin c1 = counter; tick(1'b0, '0); end
            3: tick(1'b1, exp_load(c.ld, counter, counter));
            4: tick(1'b1, exp_load(c.ld, c1, counter));
            default: tick(1'b0, '0);
         endcase
      end
      ex_data_ready   = 1'b0;
      data_rvalid_i   = 1'b0;
      wb_data_ready_i = 1'b1;
      for (int i = 0; i <= int'(DEPTH); i++) begin
         want = '0;
         if (exp_q.size() > 0) want = exp_q[0];
         total++; if (wb_data_o !== want || wb_data_valid_o !== (exp_q.size() > 0)) begin
            bad++; $display("FAIL rnd_drain%0d: got valid=%b data=%h want %h", i, wb_data_valid_o, wb_data_o, want);
         end
         tick(1'b0, '0);
      end
      total++; if (wb_data_valid_o !== 1'b0) begin bad++; $display("FAIL rnd_empty: got %b want 0", wb_data_valid_o); end
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_load();
      test_held();
      test_overflow();
      test_full_push_pop();
      test_reset_wait();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
